booth_control: RTL and testbench
================================

// Module: booth_control
// PURPOSE
//  Control unit for the radix-2 Booth multiplier datapath; sits beside it and closes the loop.
//  Consumes the datapath's Booth pair q = {Q0, Q-1}.
//  Drives its start / resta / desp / fin strobes and runs N add-or-subtract/shift iterations.
//  Registers the final 2N-bit product; user side is a start pulse in, ocupado/valido out.
// PARAMETERS
//  N        3         multiplier/multiplicand width in bits (iterations per product)
//  CNT_W    $clog2(N+1) iteration counter width (derived, do not override)
// PORTS
//  clk        in   1    system clock, all state on rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  inicio     in   1    request: begin a multiplication (sampled only in IDLE)
//  q          in   2    Booth pair from datapath {Q0, Q-1}
//  resultado  in   2N   datapath product {A[N-1:0], Q[N:1]}
//  start      out  1    datapath load: load Q/M, clear A
//  resta      out  1    datapath adder mode: 1 = A-M, 0 = A+M
//  desp       out  1    datapath arithmetic right shift of A:Q
//  fin        out  1    datapath A-load inhibit (1 = A holds unless desp)
//  ocupado    out  1    multiplication in progress
//  valido     out  1    one-cycle pulse: producto updated
//  producto   out  2N   registered product, held until next valido
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, cnt=0, producto=0, valido=0, start=resta=desp=0, fin=1, ocupado=0.
//  - FSM states:
//    - IDLE: fin=1. If inicio, go to CARGA; else stay.
//    - CARGA: start=1, fin=1, cnt<=0. Next state: OPER.
//    - OPER (Mealy on q):
//      - q=01: fin=0, resta=0 (A<=A+M).
//      - q=10: fin=0, resta=1 (A<=A-M).
//      - q=00/11: fin=1 (no A load).
//      - desp=0 in all cases. Next state: DESP.
//    - DESP: desp=1, fin=0, cnt<=cnt+1. Next state: HECHO if cnt==N-1, else OPER.
//    - HECHO: fin=1. producto<=resultado; valido<=1 (registered, high the cycle after HECHO). Next state: IDLE.
//  - ocupado=1 in CARGA, OPER, DESP and HECHO.
//  - Latency: inicio high at edge k -> CARGA in cycle k+1 -> valido high in cycle k+3+2N (N=3: k+9).
//  - Back-to-back requests: inicio in the same cycle valido is high is accepted; there are no dead cycles beyond IDLE.
//  - inicio while ocupado: ignored, not queued.
//  - Strobe exclusivity: start, desp and (~fin & ~desp) are mutually exclusive in every cycle. A stuck q value does not change the iteration count.
//  - rst_n low mid-operation: immediate return to reset values. producto is cleared and no valido is issued.
//  - Arithmetic is done entirely in the datapath; this block performs no arithmetic except cnt.
// CONFIGURATION
//  BOOTH_FAST_EN
//   - defined: in OPER with q=00/11, assert desp=1, fin=0 in that cycle and increment cnt, skipping DESP.
//     The next state is OPER (or HECHO on the last iteration). Latency is data-dependent, min k+3+N.
//   - undefined: fixed 2 cycles per iteration exactly as above.
// STRUCTURE
//  - booth_pkg: state enum {IDLE,CARGA,OPER,DESP,HECHO}, Booth pair constants Q_SUMA=2'b01, Q_RESTA=2'b10, default N.
//  - Sub-module booth_iter_cnt: CNT_W counter with clear, increment and ultimo (cnt==N-1) flag.
//  - Remainder: state register, Mealy output decode, producto/valido register.
// TESTING
//  1. Reset: hold rst_n=0 with inicio=1 -> fin=1, all other outputs 0; no CARGA after release until inicio is seen in IDLE.
//  2. 3 x -2 (N=3, multiplier=011, multiplicand=110) with the datapath model attached
//     -> producto=6'b111010 (-6), valido in cycle k+9, one-cycle pulse.
//  3. q held at 00 for a whole run -> resta never used, fin=0 only in DESP, exactly 3 desp pulses, then HECHO.
//  4. inicio reasserted every cycle during a run -> no restart; a second run starts on the cycle valido is high; 2nd result correct.
//  5. rst_n dropped in the second OPER cycle -> outputs at reset values asynchronously; producto=0, no valido.
//  6. BOOTH_FAST_EN, multiplier=000 -> valido at k+6; the same stimulus without the macro gives k+9; producto=0 in both builds.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control unit.
package booth_pkg;

    localparam int unsigned N_DEF = 3;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] IDLE  = 3'd0;
    localparam logic [ST_W-1:0] CARGA = 3'd1;
    localparam logic [ST_W-1:0] OPER  = 3'd2;
    localparam logic [ST_W-1:0] DESP  = 3'd3;
    localparam logic [ST_W-1:0] HECHO = 3'd4;

    localparam logic [1:0] Q_SUMA  = 2'b01;
    localparam logic [1:0] Q_RESTA = 2'b10;

    // Datapath strobe bundle; fin=1 is the quiescent "A holds" level.
    typedef struct packed {
        logic start;
        logic resta;
        logic desp;
        logic fin;
    } booth_strobe_t;

    localparam booth_strobe_t STRB_REPOSO = '{start: 1'b0, resta: 1'b0, desp: 1'b0, fin: 1'b1};

endpackage

// File: rtl/booth_control_if.sv
// Handshake and datapath strobe bundle between the Booth control unit and its surroundings.
interface booth_control_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned PW = 2 * N;

    logic          inicio;
    logic [1:0]    q;
    logic [PW-1:0] resultado;
    logic          start;
    logic          resta;
    logic          desp;
    logic          fin;
    logic          ocupado;
    logic          valido;
    logic [PW-1:0] producto;

    // Control unit side
    modport master (
        input  inicio, q, resultado,
        output start, resta, desp, fin, ocupado, valido, producto
    );

    // User + datapath side
    modport slave (
        output inicio, q, resultado,
        input  start, resta, desp, fin, ocupado, valido, producto
    );
endinterface

// File: rtl/booth_iter_cnt.sv
// Iteration counter: clear, increment and a registered last-iteration flag (cnt == N-1).
module booth_iter_cnt #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic ultimo_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ultimo_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Flag tracks the next count so it is valid in the same cycle as cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ultimo_q <= 1'(N == 1);
        end else begin
            cnt_q    <= cnt_d;
            ultimo_q <= (cnt_d == CNT_W'(N - 1));
        end
    end

    assign ultimo_o = ultimo_q;

endmodule

// File: rtl/booth_control.sv
// Radix-2 Booth multiplier control unit: sequences load, add/sub and shift strobes, registers product.
// Optional BOOTH_FAST_EN: q=00/11 iterations shift directly from OPER, skipping DESP.
module booth_control
    import booth_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input logic             clk,
    input logic             rst_n,
    booth_control_if.master bus
);
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned PW    = 2 * N;

    logic [ST_W-1:0] state_q, state_d;
    booth_strobe_t   strb_c;
    logic            cnt_clr_c;
    logic            cnt_inc_c;
    logic            ultimo;
    logic [PW-1:0]   producto_q, producto_d;
    logic            valido_q, valido_d;

    booth_iter_cnt #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr_c),
        .inc_i    (cnt_inc_c),
        .ultimo_o (ultimo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            producto_q <= '0;
            valido_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            producto_q <= producto_d;
            valido_q   <= valido_d;
        end
    end

    // Next state and Mealy strobe decode
    always_comb begin
        state_d    = state_q;
        strb_c     = STRB_REPOSO;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        producto_d = producto_q;
        valido_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.inicio) begin
                    state_d = CARGA;
                end
            end
            CARGA: begin
                strb_c.start = 1'b1;
                cnt_clr_c    = 1'b1;
                state_d      = OPER;
            end
            OPER: begin
                state_d = DESP;
                if (bus.q == Q_SUMA) begin
                    strb_c.fin = 1'b0;
                end else if (bus.q == Q_RESTA) begin
                    strb_c.fin   = 1'b0;
                    strb_c.resta = 1'b1;
                end
`ifdef BOOTH_FAST_EN
                else begin
                    strb_c.fin  = 1'b0;
                    strb_c.desp = 1'b1;
                    cnt_inc_c   = 1'b1;
                    state_d     = ultimo ? HECHO : OPER;
                end
`endif
            end
            DESP: begin
                strb_c.fin  = 1'b0;
                strb_c.desp = 1'b1;
                cnt_inc_c   = 1'b1;
                state_d     = ultimo ? HECHO : OPER;
            end
            HECHO: begin
                producto_d = bus.resultado;
                valido_d   = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.start    = strb_c.start;
    assign bus.resta    = strb_c.resta;
    assign bus.desp     = strb_c.desp;
    assign bus.fin      = strb_c.fin;
    assign bus.ocupado  = (state_q != IDLE);
    assign bus.valido   = valido_q;
    assign bus.producto = producto_q;

endmodule

// File: tb/tb_booth_control.sv
// Self-checking bench for booth_control with an attached behavioural Booth datapath.
module tb_booth_control;
    localparam int unsigned N  = 3;
    localparam int unsigned PW = 2 * N;

    logic         clk;
    logic         rst_n;
    logic         inicio;
    logic         q_force;
    logic [N-1:0] mplier;
    logic [N-1:0] mcand;

    int n_checks = 0;
    int n_fail   = 0;

    booth_control_if #(.N(N)) bus ();

    booth_control #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: A (N bits), Q with appended Q-1 (N+1 bits), M.
    logic [N-1:0] dp_a;
    logic [N-1:0] dp_m;
    logic [N:0]   dp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a <= '0;
            dp_m <= '0;
            dp_q <= '0;
        end else if (bus.start) begin
            dp_a <= '0;
            dp_m <= mcand;
            dp_q <= {mplier, 1'b0};
        end else if (bus.desp) begin
            {dp_a, dp_q} <= {dp_a[N-1], dp_a, dp_q[N:1]};
        end else if (!bus.fin) begin
            dp_a <= bus.resta ? (dp_a - dp_m) : (dp_a + dp_m);
        end
    end

    assign bus.inicio    = inicio;
    assign bus.q         = q_force ? 2'b00 : dp_q[1:0];
    assign bus.resultado = {dp_a, dp_q[N:1]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_prod(input logic [N-1:0] mp, input logic [N-1:0] mc);
        int a;
        int b;
        a = $signed(mp);
        b = $signed(mc);
        return PW'(a * b);
    endfunction

    // Cycles from the inicio-sampling edge to the valido cycle.
    function automatic int ref_lat(input logic [N-1:0] mp, input bit frc);
        int   act;
        logic prev;
        act  = 0;
        prev = 1'b0;
        if (!frc) begin
            for (int i = 0; i < int'(N); i++) begin
                if (mp[i] != prev) act++;
                prev = mp[i];
            end
        end
`ifdef BOOTH_FAST_EN
        return 3 + int'(N) + act;
`else
        return 3 + 2 * int'(N) + 0 * act;
`endif
    endfunction

    // Runs one multiplication; returns at the negedge of the valido cycle.
    task automatic run_op(input logic [N-1:0] mp, input logic [N-1:0] mc,
                          input bit frc, input bit keep, input string tag);
        int lat, n_desp, n_excl, n_idle, n_resta, n_fin0, strb;
        lat = -1; n_desp = 0; n_excl = 0; n_idle = 0; n_resta = 0; n_fin0 = 0;
        mplier  = mp;
        mcand   = mc;
        q_force = frc;
        inicio  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!keep) inicio = 1'b0;
            if (bus.valido) begin
                lat = c;
                break;
            end
            strb = int'(bus.start) + int'(bus.desp) + int'(!bus.fin && !bus.desp);
            if (strb > 1)                 n_excl++;
            if (bus.desp)                 n_desp++;
            if (!bus.ocupado)             n_idle++;
            if (bus.resta)                n_resta++;
            if (!bus.fin && !bus.desp)    n_fin0++;
        end
        q_force = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(ref_lat(mp, frc)));
        check({tag, "_desp_pulses"}, 32'(n_desp), 32'(N));
        check({tag, "_strobe_excl"}, 32'(n_excl), 32'd0);
        check({tag, "_busy"}, 32'(n_idle), 32'd0);
        if (frc) begin
            check({tag, "_resta_used"}, 32'(n_resta), 32'd0);
            check({tag, "_fin0_outside_desp"}, 32'(n_fin0), 32'd0);
        end else begin
            check({tag, "_producto"}, 32'(bus.producto), 32'(ref_prod(mp, mc)));
        end
    endtask

    task automatic check_after(input string tag, input logic [PW-1:0] exp_prod);
        @(negedge clk);
        check({tag, "_valido_pulse"}, 32'(bus.valido), 32'd0);
        check({tag, "_idle"}, 32'(bus.ocupado), 32'd0);
        check({tag, "_hold"}, 32'(bus.producto), 32'(exp_prod));
    endtask

    initial begin
        logic [N-1:0] mp, mc;
        logic [N-1:0] mc_min;
        int           n_val;
        mc_min  = {1'b1, {(N - 1){1'b0}}};
        rst_n   = 1'b1;
        inicio  = 1'b0;
        q_force = 1'b0;
        mplier  = '0;
        mcand   = '0;

        // Reset with inicio asserted
        #3;
        rst_n  = 1'b0;
        inicio = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fin", 32'(bus.fin), 32'd1);
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_resta", 32'(bus.resta), 32'd0);
        check("rst_desp", 32'(bus.desp), 32'd0);
        check("rst_ocupado", 32'(bus.ocupado), 32'd0);
        check("rst_valido", 32'(bus.valido), 32'd0);
        check("rst_producto", 32'(bus.producto), 32'd0);
        inicio = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_carga", 32'(bus.ocupado), 32'd0);

        // 3 x -2
        run_op(3'b011, 3'b110, 1'b0, 1'b0, "mul_3x_m2");
        check("mul_3x_m2_const", 32'(bus.producto), 32'(6'b111010));
        check_after("mul_3x_m2", 6'b111010);

        // q stuck at 00
        run_op(3'b101, 3'b011, 1'b1, 1'b0, "q_stuck00");
        @(negedge clk);

        // Boundary: most negative multiplier, zero multiplier
        run_op(3'b100, 3'b011, 1'b0, 1'b0, "mp_min");
        check_after("mp_min", ref_prod(3'b100, 3'b011));
        run_op(3'b000, 3'b101, 1'b0, 1'b0, "mp_zero");
        check("mp_zero_const", 32'(bus.producto), 32'd0);
        check_after("mp_zero", '0);

        // inicio held through a run, then back-to-back second run
        run_op(3'b010, 3'b111, 1'b0, 1'b1, "b2b_first");
        run_op(3'b101, 3'b011, 1'b0, 1'b0, "b2b_second");
        check_after("b2b_second", ref_prod(3'b101, 3'b011));

        // Randomised operands; most negative multiplicand overflows an N-bit A
        for (int i = 0; i < 10; i++) begin
            mp = N'($urandom_range(0, (1 << N) - 1));
            mc = N'($urandom_range(0, (1 << N) - 1));
            if (mc == mc_min) mc = mc + N'(1);
            run_op(mp, mc, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end
        @(negedge clk);

        // Reset dropped during the second OPER cycle
        mplier = 3'b011;
        mcand  = 3'b110;
        inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ocupado", 32'(bus.ocupado), 32'd0);
        check("midrst_fin", 32'(bus.fin), 32'd1);
        check("midrst_desp", 32'(bus.desp), 32'd0);
        check("midrst_start", 32'(bus.start), 32'd0);
        check("midrst_producto", 32'(bus.producto), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_val = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.valido || bus.ocupado) n_val++;
        end
        check("midrst_no_valido", 32'(n_val), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
